// File: rtl/wire_pkg.sv
// Shared types for the triangle wireframe rasterizer.
//   WOI      : coordinate width (unsigned screen pixels)
//   COLOR_W  : pixel colour width
//   coord_t  : one screen coordinate
//   err_t    : signed midpoint error / delta, two bits wider than a coordinate
//   state_t  : rasterizer FSM states
//   vertex_t : packed {y, x}; bit layout matches a [1:0][WOI-1:0] vertex port
package wire_pkg;
  localparam int WOI     = 10;
  localparam int COLOR_W = 8;

  typedef logic [WOI-1:0]        coord_t;
  typedef logic signed [WOI+1:0] err_t;

  typedef enum logic [1:0] {IDLE, SETUP, STEP, DONE} state_t;

  typedef struct packed {
    coord_t y;
    coord_t x;
  } vertex_t;
endpackage

// File: rtl/midpoint_line_stepper.sv
// Per-edge Bresenham datapath. i_load captures one edge (start/end) and
// derives the deltas and step directions; i_advance moves one position.
// The next point is exposed combinationally so the owner can register it
// into its pixel output in the same cycle the step is taken.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_load                capture edge i_x0,i_y0 -> i_x1,i_y1
//   i_advance             take one midpoint step
//   o_zero                the edge on the inputs has zero length
//   o_nx, o_ny            position after the next step
//   o_next_at_end         that position is the (excluded) edge end point
module midpoint_line_stepper
  import wire_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_load,
  input  logic           i_advance,
  input  logic [WOI-1:0] i_x0,
  input  logic [WOI-1:0] i_y0,
  input  logic [WOI-1:0] i_x1,
  input  logic [WOI-1:0] i_y1,
  output logic           o_zero,
  output logic [WOI-1:0] o_nx,
  output logic [WOI-1:0] o_ny,
  output logic           o_next_at_end
);
  coord_t r_x, r_y, r_ex, r_ey;
  err_t   r_dx, r_dy, r_err;
  logic   r_sx_neg, r_sy_neg;

  err_t w_ddx, w_ddy, w_adx, w_ady, w_nerr;
  logic signed [WOI+2:0] w_e2, w_dx_ext, w_dy_ext;
  logic   w_stx, w_sty;
  coord_t w_nx, w_ny;

  assign w_ddx = err_t'({2'b00, i_x1}) - err_t'({2'b00, i_x0});
  assign w_ddy = err_t'({2'b00, i_y1}) - err_t'({2'b00, i_y0});
  assign w_adx = w_ddx[WOI+1] ? -w_ddx : w_ddx;
  assign w_ady = w_ddy[WOI+1] ? -w_ddy : w_ddy;
  assign o_zero = (i_x0 == i_x1) && (i_y0 == i_y1);

  // 2*err gets one extra bit so the comparison against dx/dy cannot wrap.
  assign w_e2     = {r_err, 1'b0};
  assign w_dx_ext = {r_dx[WOI+1], r_dx};
  assign w_dy_ext = {r_dy[WOI+1], r_dy};
  assign w_stx    = (w_e2 >= w_dy_ext);
  assign w_sty    = (w_e2 <= w_dx_ext);

  // Both decisions use the same e2, so a diagonal step updates err twice.
  assign w_nerr = r_err + (w_stx ? r_dy : err_t'(0)) + (w_sty ? r_dx : err_t'(0));
  assign w_nx   = w_stx ? (r_sx_neg ? r_x - coord_t'(1) : r_x + coord_t'(1)) : r_x;
  assign w_ny   = w_sty ? (r_sy_neg ? r_y - coord_t'(1) : r_y + coord_t'(1)) : r_y;

  assign o_nx          = w_nx;
  assign o_ny          = w_ny;
  assign o_next_at_end = (w_nx == r_ex) && (w_ny == r_ey);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x <= '0; r_y <= '0; r_ex <= '0; r_ey <= '0;
      r_dx <= '0; r_dy <= '0; r_err <= '0;
      r_sx_neg <= 1'b0; r_sy_neg <= 1'b0;
    end else if (i_load) begin
      r_x      <= i_x0;
      r_y      <= i_y0;
      r_ex     <= i_x1;
      r_ey     <= i_y1;
      r_dx     <= w_adx;
      r_dy     <= -w_ady;
      r_err    <= w_adx - w_ady;
      r_sx_neg <= w_ddx[WOI+1];
      r_sy_neg <= w_ddy[WOI+1];
    end else if (i_advance) begin
      r_x   <= w_nx;
      r_y   <= w_ny;
      r_err <= w_nerr;
    end
  end
endmodule

// File: rtl/triangle_wireframe_rasterizer.sv
// Wireframe triangle rasterizer: accepts one triangle per handshake and
// walks V1->V2, V2->V3, V3->V1 (start-inclusive, end-exclusive), emitting
// one pixel write per handshake on a valid/ready stream.
// Optional feature macro: WIREFRAME_CLIP_EN -- pixels with x>=width or
// y>=height are stepped through but not presented.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_tri_valid / o_tri_ready      triangle handshake
//   i_v1, i_v2, i_v3               vertices, [0]=x [1]=y
//   i_color                        triangle colour
//   i_width, i_height              framebuffer size (clip builds only)
//   o_pix_valid / i_pix_ready      pixel handshake
//   o_pix_x, o_pix_y, o_pix_color  pixel write
//   o_busy                         triangle in progress
//   o_done                         one-cycle pulse after the final pixel
module triangle_wireframe_rasterizer
  import wire_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tri_valid,
  output logic                  o_tri_ready,
  input  logic [1:0][WOI-1:0]   i_v1,
  input  logic [1:0][WOI-1:0]   i_v2,
  input  logic [1:0][WOI-1:0]   i_v3,
  input  logic [COLOR_W-1:0]    i_color,
  input  logic [WOI-1:0]        i_width,
  input  logic [WOI-1:0]        i_height,
  output logic                  o_pix_valid,
  input  logic                  i_pix_ready,
  output logic [WOI-1:0]        o_pix_x,
  output logic [WOI-1:0]        o_pix_y,
  output logic [COLOR_W-1:0]    o_pix_color,
  output logic                  o_busy,
  output logic                  o_done
);
  state_t               r_state;
  vertex_t              r_v1, r_v2, r_v3;
  logic [1:0]           r_edge;
  logic                 r_single;
  logic                 r_tri_ready, r_pix_valid, r_busy, r_done;
  coord_t               r_pix_x, r_pix_y;
  logic [COLOR_W-1:0]   r_pix_color;

  vertex_t w_p0, w_p1;
  logic    w_zero, w_next_at_end, w_all_eq, w_last_edge, w_adv;
  logic    w_vis0, w_visn;
  coord_t  w_nx, w_ny;

  always_comb begin
    w_p0 = r_v3;
    w_p1 = r_v1;
    case (r_edge)
      2'd0:    begin w_p0 = r_v1; w_p1 = r_v2; end
      2'd1:    begin w_p0 = r_v2; w_p1 = r_v3; end
      default: ;
    endcase
  end

  assign w_all_eq = (r_v1 == r_v2) && (r_v2 == r_v3);
  // When V3==V1 the closing edge is empty, so edge 1 is effectively the
  // last one; finishing there keeps done one cycle after the last pixel.
  assign w_last_edge = (r_edge == 2'd2) || ((r_edge == 2'd1) && (r_v3 == r_v1));
  // A hidden (clipped) pixel never waits for the consumer.
  assign w_adv = (r_state == STEP) && (i_pix_ready || !r_pix_valid);

`ifdef WIREFRAME_CLIP_EN
  coord_t r_width, r_height;
  assign w_vis0 = (w_p0.x < r_width) && (w_p0.y < r_height);
  assign w_visn = (w_nx < r_width) && (w_ny < r_height);
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_width  <= '0;
      r_height <= '0;
    end else if (r_state == IDLE && i_tri_valid) begin
      r_width  <= i_width;
      r_height <= i_height;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_width, i_height};
  assign w_vis0   = 1'b1;
  assign w_visn   = 1'b1;
`endif

  midpoint_line_stepper u_stepper (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_load        (r_state == SETUP),
    .i_advance     (w_adv),
    .i_x0          (w_p0.x),
    .i_y0          (w_p0.y),
    .i_x1          (w_p1.x),
    .i_y1          (w_p1.y),
    .o_zero        (w_zero),
    .o_nx          (w_nx),
    .o_ny          (w_ny),
    .o_next_at_end (w_next_at_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_v1        <= '0;
      r_v2        <= '0;
      r_v3        <= '0;
      r_edge      <= 2'd0;
      r_single    <= 1'b0;
      r_tri_ready <= 1'b1;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_color <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_tri_valid) begin
            r_v1        <= i_v1;
            r_v2        <= i_v2;
            r_v3        <= i_v3;
            r_pix_color <= i_color;
            r_edge      <= 2'd0;
            r_tri_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          // A fully collapsed triangle still produces its single vertex.
          if (!w_zero || (r_edge == 2'd0 && w_all_eq)) begin
            r_pix_x     <= w_p0.x;
            r_pix_y     <= w_p0.y;
            r_pix_valid <= w_vis0;
            r_single    <= w_zero;
            r_state     <= STEP;
          end else if (w_last_edge) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_edge <= r_edge + 2'd1;
          end
        end
        STEP: begin
          if (w_adv) begin
            if (r_single || w_next_at_end) begin
              r_pix_valid <= 1'b0;
              r_single    <= 1'b0;
              if (r_single || w_last_edge) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= DONE;
              end else begin
                r_edge  <= r_edge + 2'd1;
                r_state <= SETUP;
              end
            end else begin
              r_pix_x     <= w_nx;
              r_pix_y     <= w_ny;
              r_pix_valid <= w_visn;
            end
          end
        end
        DONE: begin
          r_done      <= 1'b0;
          r_tri_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tri_ready = r_tri_ready;
  assign o_pix_valid = r_pix_valid;
  assign o_pix_x     = r_pix_x;
  assign o_pix_y     = r_pix_y;
  assign o_pix_color = r_pix_color;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
endmodule

// File: doc/triangle_wireframe_rasterizer.md
# triangle_wireframe_rasterizer

Sequential consumer of projected screen-space triangles. Accepts one triangle (three integer vertices plus a colour) per handshake and walks edges V1→V2, V2→V3, V3→V1 with the integer midpoint (Bresenham) algorithm. It emits one framebuffer pixel write per handshake on a valid/ready pixel stream. It sits between the projection stage and the framebuffer write arbiter in the MidPoint pipeline.

## Interface
- WOI, 10, coordinate width in bits (unsigned integer pixels, matches projection output)
- COLOR_W, 8, pixel colour width

- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- tri_valid  in  1  triangle present
- tri_ready  out  1  block can accept a triangle
- V1, V2, V3  in  [1:0][WOI-1:0] each  vertex; [0]=x, [1]=y
- color  in  COLOR_W  triangle colour
- width, height  in  WOI  framebuffer size; used only when clipping is compiled in
- pix_valid  out  1  pixel write present
- pix_ready  in  1  framebuffer accepts pixel
- pix_x, pix_y  out  WOI  pixel coordinate
- pix_color  out  COLOR_W  latched colour
- busy  out  1  triangle in progress
- done  out  1  one-cycle pulse after final pixel accepted

## Operation
- Handshake: transfer on valid && ready, both ports. pix_valid, pix_x, pix_y and pix_color hold stable until accepted. pix_valid never drops without acceptance, except on Reset.
- States: IDLE → SETUP → STEP → (SETUP for next edge | DONE) → IDLE.
- IDLE: tri_ready=1. On accept, latch V1..V3, color, width, height. Set edge index 0. Go to SETUP.
- SETUP: load start/end for the current edge. Compute dx=|x1−x0|, dy=−|y1−y0|, sx/sy=±1, err=dx+dy, all signed WOI+2 bits.
  - A zero-length edge skips to the next edge's SETUP, or to DONE.
  - Otherwise go to STEP.
- STEP: present current pixel. On accept, compute e2=2·err:
  - if e2≥dy: err+=dy, x+=sx
  - if e2≤dx: err+=dx, y+=sy
  - If the new point equals the edge end, advance the edge; otherwise stay in STEP.
- Edges are start-inclusive and end-exclusive, so each vertex is emitted once. Pixel count = Σ max(|dx|,|dy|).
- All three vertices coincident: emit exactly one pixel at V1, then DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- busy=1 in SETUP, STEP and DONE-entry, i.e. from the cycle after accept until the done pulse.
- Reset in any state: next cycle is IDLE and any in-flight pixel is dropped.
  - Reset values: tri_ready=1, pix_valid=0, pix_x=pix_y=0, pix_color=0, busy=0, done=0.

## Timing
- Triangle accepted at edge N. SETUP at N+1. First pix_valid at N+2.
- Throughput is one pixel per cycle while pix_ready=1. Each edge transition inserts one SETUP bubble cycle.
- done is asserted the cycle after the last pixel handshake. tri_ready rises the cycle after done.
- pix_ready low: the state is frozen and err is not updated.

## Configuration
- WIREFRAME_CLIP_EN defined:
  - Pixels with x≥width or y≥height are not presented (pix_valid stays 0).
  - The stepper still advances one position per cycle through them.
  - done still pulses after the final edge.
- Undefined: width/height are ignored and every stepped pixel is emitted.

## Structure
- Shared package wire_pkg:
  - coord_t (WOI bits), err_t (signed WOI+2)
  - state enum {IDLE, SETUP, STEP, DONE}
  - vertex_t struct
- Sub-module midpoint_line_stepper: per-edge setup/step datapath with load, advance and at_end. The top holds the FSM, edge sequencing, latches and the pixel register.

## Test plan
- Triangle (0,0),(4,0),(0,4), pix_ready=1:
  - 12 pixels in order (0,0),(1,0),(2,0),(3,0),(4,0),(3,1),(2,2),(1,3),(0,4),(0,3),(0,2),(0,1).
  - First pixel 2 cycles after accept; done one cycle after the 12th.
- Steep edge: V1=(10,10), V2=(12,15), V3=V1:
  - First edge emits (10,10),(10,11),(11,12),(11,13),(12,14).
  - Return edge emits (12,15),(12,14),(11,13),(11,12),(10,11).
- Backpressure: drop pix_ready for 3 cycles at the 3rd pixel of test 1. pix_x/pix_y stay at (2,0); no pixel is skipped or duplicated; still 12 pixels total.
- Degenerate: all vertices (7,9) → exactly one pixel (7,9), then done pulse, then tri_ready=1.
- Reset during the 3rd pixel of test 1 → next cycle pix_valid=0, busy=0, tri_ready=1, no done. A new triangle then restarts at (0,0).
- WIREFRAME_CLIP_EN, width=640, triangle (630,0),(650,0),(630,0):
  - Edge 1 emits x=630..639 only (10 pixels), edge 2 emits x=639..631 (9 pixels), 19 in total.
  - Without the macro, 40 pixels.
